// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 4,
   parameter int unsigned AE_THRESH = 2,
   parameter bit          FWFT      = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         din,
   input  logic                     wr_en,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_almost_full;
   logic             r_almost_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_rd_acc;
   logic             w_wr_acc;
   logic [CW-1:0]    w_count_nxt;
   logic             w_full_nxt;
   logic             w_empty_nxt;
   logic             w_almost_full_nxt;
   logic             w_almost_empty_nxt;

   // Accept logic: a read frees a slot, so a write into a full FIFO succeeds alongside it.
   always_comb begin
      w_rd_acc = 1'b0;
      w_wr_acc = 1'b0;
      w_rd_acc = rd_en && !r_empty;
      w_wr_acc = wr_en && (!r_full || w_rd_acc);
   end

   // Next occupancy and the flags derived from it, so flags and count move together.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
      w_full_nxt         = (w_count_nxt == CW'(DEPTH));
      w_empty_nxt        = (w_count_nxt == {CW{1'b0}});
      w_almost_full_nxt  = (w_count_nxt >= CW'(AF_THRESH));
      w_almost_empty_nxt = (w_count_nxt <= CW'(AE_THRESH));
   end

   // Pointer, occupancy, flag and error-pulse registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr       <= {AW{1'b0}};
         r_rd_ptr       <= {AW{1'b0}};
         r_count        <= {CW{1'b0}};
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count        <= w_count_nxt;
         r_full         <= w_full_nxt;
         r_empty        <= w_empty_nxt;
         r_almost_full  <= w_almost_full_nxt;
         r_almost_empty <= w_almost_empty_nxt;
         r_overflow     <= wr_en && r_full && !w_rd_acc;
         r_underflow    <= rd_en && r_empty;
      end
   end

   // Storage array; deliberately not cleared by reset, only writes are blocked.
   always_ff @(posedge clk) begin
      if (rst && w_wr_acc) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented directly; it depends only on the registered read pointer.
         assign dout       = r_mem[r_rd_ptr];
         assign dout_valid = !r_empty;
      end else begin : g_std
         logic [WIDTH-1:0] r_dout;
         logic             r_dout_valid;

         // Registered read port: one-cycle latency, data held between reads.
         always_ff @(posedge clk) begin
            if (!rst) begin
               r_dout       <= {WIDTH{1'b0}};
               r_dout_valid <= 1'b0;
            end else begin
               r_dout_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_dout <= r_mem[r_rd_ptr];
               end
            end
         end

         assign dout       = r_dout;
         assign dout_valid = r_dout_valid;
      end
   endgenerate

   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the basic synchronous FIFO. It is a single-clock FIFO with configurable width and depth, and it adds:
- occupancy count
- almost-full and almost-empty thresholds
- overflow and underflow error pulses
- a selectable first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer on the same clock, as a drop-in upgrade for the existing FIFO users.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
din  input  WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (in FWFT mode: pop/acknowledge)
dout  output  WIDTH  read data
dout_valid  output  1  dout holds valid read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: a write was rejected
underflow  output  1  one-cycle pulse: a read was rejected

Behaviour:
- Reset applies when rst==0 at a clk rising edge; it has priority over all other inputs.
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1.
  - almost_full=0 (AF_THRESH>=1), overflow=0, underflow=0.
  - dout=0 in standard mode; dout_valid=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored data. A wr_en or rd_en asserted in the reset cycle has no effect.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous read frees a slot, so the write is accepted.
- When empty and both rd_en and wr_en are high: write only, rd_acc=0, underflow pulses. There is no bypass path.
- Accepted write: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH)-bit pointer).
- Accepted read: rd_ptr increments modulo DEPTH.
- count next value:
  - count+1 when wr_acc && !rd_acc
  - count-1 when rd_acc && !wr_acc
  - unchanged otherwise
- All flags (full, empty, almost_full, almost_empty) are registered and derived from count's next value, so they are valid in the same cycle count updates.
- overflow <= wr_en && full && !rd_acc. Registered, high for exactly one cycle per rejected write. State is unchanged.
- underflow <= rd_en && empty. Registered, one cycle. State is unchanged.
- FWFT=0 (standard mode):
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 at the same edge. Read latency is 1 cycle.
  - dout_valid is high for exactly one cycle per accepted read.
  - dout holds its last value when no read is accepted.
- FWFT=1 (fall-through mode):
  - dout = mem[rd_ptr] (unregistered read of the storage array); dout_valid = !empty.
  - A word written into an empty FIFO appears on dout, with dout_valid=1, the cycle after the write edge.
  - rd_en pops the current word; the next word is visible the following cycle.
  - dout is don't-care while dout_valid=0.
- Throughput: one write and one read per cycle sustained. No combinational path from wr_en or rd_en to any output, except dout in FWFT mode (depends on rd_ptr only).

Test Plan:
1. Reset and fill (WIDTH=8, DEPTH=16, AF=12, AE=2, FWFT=0):
   - Stimulus: rst=0 for 2 cycles, then write 0x01..0x10 on 16 consecutive cycles.
   - Required: count steps 0..16. almost_empty falls when count goes 2->3. almost_full rises at 12. full rises at 16. No overflow.
2. Overflow, then drain:
   - Stimulus: from full, a 17th write of 0xAA. Then rd_en for 16 cycles.
   - Required: overflow pulses 1 cycle; count stays 16. dout_valid pulses each cycle with 0x01..0x10 in order, 1 cycle after each rd_en. empty=1 at the end. The 0xAA write is lost.
3. Underflow and simultaneous access:
   - Stimulus: rd_en on empty. Then from count=16, wr_en=rd_en=1 with din=0x55.
   - Required: underflow pulses 1 cycle with count 0. At full, both accepted: count stays 16, no overflow, 0x55 read last.
4. Wrap-around:
   - Stimulus: 40 cycles of concurrent write/read, keeping count at 5.
   - Required: pointers wrap at 16 twice. Read data matches written order (scoreboard), count constant at 5.
5. FWFT mode (FWFT=1):
   - Stimulus: write 0x3C into empty FIFO. Next cycle rd_en=1. Then write 0x11 and 0x22; rd_en pulses one per cycle.
   - Required: dout=0x3C with dout_valid=1 on the cycle after the write. It pops on rd_en and dout_valid drops. Then dout shows 0x11, then 0x22.
6. Reset mid-operation:
   - Stimulus: with count=9, assert rst=0 for 1 cycle with wr_en=1.
   - Required: next cycle count=0, empty=1, dout_valid=0, no write stored. A subsequent read gives underflow.
